lpm_fifo_dc_rdflags: RTL and testbench



---
 rtl/lpm_fifo_dc_rdflags.sv | 92 +++++++++
 tb/tb_lpm_fifo_dc_rdflags.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/lpm_fifo_dc_rdflags.sv
// Read-side pointer and flag stage of the dual-clock LPM FIFO.
// Compares the local read pointer with the synchronised write pointer and registers every flag.
module lpm_fifo_dc_rdflags #(
    parameter int    lpm_widthad            = 8,
    parameter int    lpm_almost_empty_value = 2,
    parameter string underflow_checking     = "ON"
) (
    input  logic                   clock,
    input  logic                   sclr,
    input  logic                   rdreq,
    input  logic [lpm_widthad:0]   wrptr_sync,
    output logic [lpm_widthad-1:0] rdaddr,
    output logic [lpm_widthad:0]   rd_ptr,
    output logic [lpm_widthad-1:0] rdusedw,
    output logic                   rdempty,
    output logic                   rdfull,
    output logic                   rdalmostempty,
    output logic                   rderr
);

    localparam int            W          = lpm_widthad + 1;
    localparam logic [W-1:0]  DEPTH_W    = {1'b1, {lpm_widthad{1'b0}}};
    localparam logic [W-1:0]  AE_THRESH  = W'(lpm_almost_empty_value);
    localparam bit            READ_BLIND = (underflow_checking == "OFF");

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_NORMAL,
        ST_FULL,
        ST_ERR
    } state_t;

    state_t                   state_reg;
    state_t                   state_next;
    logic [W-1:0]             rd_ptr_reg;
    logic [W-1:0]             rd_ptr_next;
    logic [W-1:0]             diff;
    logic                     rd_en;
    logic [lpm_widthad-1:0]   rdusedw_reg;
    logic                     rdempty_reg;
    logic                     rdfull_reg;
    logic                     rdalmostempty_reg;
    logic                     rderr_reg;

    // ERR freezes the pointer even when the underflow guard is disabled.
    always_comb begin
        rd_en       = rdreq & (state_reg != ST_ERR) & (~rdempty_reg | READ_BLIND);
        rd_ptr_next = rd_ptr_reg + W'(rd_en);
        diff        = wrptr_sync - rd_ptr_next;

        state_next = state_reg;
        if (state_reg != ST_ERR) begin
            if (diff == '0)
                state_next = ST_EMPTY;
            else if (diff < DEPTH_W)
                state_next = ST_NORMAL;
            else if (diff == DEPTH_W)
                state_next = ST_FULL;
            else
                state_next = ST_ERR;
        end
    end

    always_ff @(posedge clock) begin
        if (sclr) begin
            state_reg         <= ST_EMPTY;
            rd_ptr_reg        <= '0;
            rdusedw_reg       <= '0;
            rdempty_reg       <= 1'b1;
            rdfull_reg        <= 1'b0;
            rdalmostempty_reg <= 1'b1;
            rderr_reg         <= 1'b0;
        end else begin
            state_reg         <= state_next;
            rd_ptr_reg        <= rd_ptr_next;
            rdusedw_reg       <= diff[lpm_widthad-1:0];
            rdalmostempty_reg <= (diff < AE_THRESH);
            rdempty_reg       <= (state_next == ST_EMPTY) || (state_next == ST_ERR);
            rdfull_reg        <= (state_next == ST_FULL);
            rderr_reg         <= (state_next == ST_ERR);
        end
    end

    assign rd_ptr        = rd_ptr_reg;
    assign rdaddr        = rd_ptr_reg[lpm_widthad-1:0];
    assign rdusedw       = rdusedw_reg;
    assign rdempty       = rdempty_reg;
    assign rdfull        = rdfull_reg;
    assign rdalmostempty = rdalmostempty_reg;
    assign rderr         = rderr_reg;

endmodule

// File: tb/tb_lpm_fifo_dc_rdflags.sv
// Bench for lpm_fifo_dc_rdflags: one instance with the underflow guard on, one with it off,
// driven by shared directed then random stimulus and checked against a counting model.
module tb_lpm_fifo_dc_rdflags;

    logic       clock;
    logic       sclr;
    logic       rdreq;
    logic [3:0] wrptr_sync;

    logic [2:0] rdaddr_o        [2];
    logic [3:0] rd_ptr_o        [2];
    logic [2:0] rdusedw_o       [2];
    logic       rdempty_o       [2];
    logic       rdfull_o        [2];
    logic       rdalmostempty_o [2];
    logic       rderr_o         [2];

    int tests = 0;
    int fails = 0;

    // Model: read count and write position as plain integers, occupancy from their difference.
    int  m_rd    [2];
    bit  m_empty [2];
    bit  m_err   [2];
    int  m_used  [2];
    bit  m_full  [2];
    bit  m_ae    [2];
    int  cur_wp;

    lpm_fifo_dc_rdflags #(
        .lpm_widthad(3), .lpm_almost_empty_value(2), .underflow_checking("ON")
    ) dut_on (
        .clock(clock), .sclr(sclr), .rdreq(rdreq), .wrptr_sync(wrptr_sync),
        .rdaddr(rdaddr_o[0]), .rd_ptr(rd_ptr_o[0]), .rdusedw(rdusedw_o[0]),
        .rdempty(rdempty_o[0]), .rdfull(rdfull_o[0]),
        .rdalmostempty(rdalmostempty_o[0]), .rderr(rderr_o[0])
    );

    lpm_fifo_dc_rdflags #(
        .lpm_widthad(3), .lpm_almost_empty_value(2), .underflow_checking("OFF")
    ) dut_off (
        .clock(clock), .sclr(sclr), .rdreq(rdreq), .wrptr_sync(wrptr_sync),
        .rdaddr(rdaddr_o[1]), .rd_ptr(rd_ptr_o[1]), .rdusedw(rdusedw_o[1]),
        .rdempty(rdempty_o[1]), .rdfull(rdfull_o[1]),
        .rdalmostempty(rdalmostempty_o[1]), .rderr(rderr_o[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit sr, input bit rq, input int wp);
        for (int i = 0; i < 2; i++) begin
            if (sr) begin
                m_rd[i] = 0; m_used[i] = 0; m_empty[i] = 1'b1;
                m_full[i] = 1'b0; m_ae[i] = 1'b1; m_err[i] = 1'b0;
            end else begin
                int d;
                if (rq && !m_err[i] && (!m_empty[i] || i == 1))
                    m_rd[i] = (m_rd[i] + 1) % 16;
                d = (wp - m_rd[i] + 16) % 16;
                m_used[i] = d % 8;
                m_ae[i]   = (d < 2);
                if (d > 8) m_err[i] = 1'b1;
                m_empty[i] = m_err[i] || (d == 0);
                m_full[i]  = !m_err[i] && (d == 8);
            end
        end
    endtask

    task automatic check_all(input string where);
        for (int i = 0; i < 2; i++) begin
            string s;
            s = $sformatf("%s/dut%0d", where, i);
            chk({s, ".rd_ptr"},        32'(rd_ptr_o[i]),        32'(m_rd[i]));
            chk({s, ".rdaddr"},        32'(rdaddr_o[i]),        32'(m_rd[i] % 8));
            chk({s, ".rdusedw"},       32'(rdusedw_o[i]),       32'(m_used[i]));
            chk({s, ".rdempty"},       32'(rdempty_o[i]),       32'(m_empty[i]));
            chk({s, ".rdfull"},        32'(rdfull_o[i]),        32'(m_full[i]));
            chk({s, ".rdalmostempty"}, 32'(rdalmostempty_o[i]), 32'(m_ae[i]));
            chk({s, ".rderr"},         32'(rderr_o[i]),         32'(m_err[i]));
        end
    endtask

    task automatic step(input string where, input bit sr, input bit rq, input int wp);
        @(negedge clock);
        sclr = sr; rdreq = rq; wrptr_sync = 4'(wp); cur_wp = wp % 16;
        @(posedge clock);
        model_edge(sr, rq, wp % 16);
        #1;
        check_all(where);
        $display("[TB] %s sclr=%0b rdreq=%0b wp=%0d -> on:ptr=%0d used=%0d e=%0b f=%0b ae=%0b err=%0b | off:ptr=%0d err=%0b",
                 where, sr, rq, wp % 16, rd_ptr_o[0], rdusedw_o[0], rdempty_o[0], rdfull_o[0],
                 rdalmostempty_o[0], rderr_o[0], rd_ptr_o[1], rderr_o[1]);
    endtask

    initial begin
        sclr = 1'b1; rdreq = 1'b0; wrptr_sync = '0; cur_wp = 0;
        for (int i = 0; i < 2; i++) model_edge(1'b1, 1'b0, 0);

        // Reset with a non-zero write pointer present
        step("rst", 1, 0, 5);
        step("rst", 1, 0, 5);
        chk("rst.rd_ptr", 32'(rd_ptr_o[0]), 0);
        chk("rst.rdempty", 32'(rdempty_o[0]), 1);
        chk("rst.rdalmostempty", 32'(rdalmostempty_o[0]), 1);
        chk("rst.rdusedw", 32'(rdusedw_o[0]), 0);
        chk("rst.rderr", 32'(rderr_o[0]), 0);
        step("post_rst", 0, 0, 5);
        chk("post_rst.rdusedw", 32'(rdusedw_o[0]), 5);
        chk("post_rst.rdempty", 32'(rdempty_o[0]), 0);
        chk("post_rst.rdalmostempty", 32'(rdalmostempty_o[0]), 0);

        // Drain three words with rdreq held for five cycles
        step("drain_rst", 1, 0, 3);
        step("drain_fill", 0, 0, 3);
        for (int k = 0; k < 5; k++) begin
            step($sformatf("drain%0d", k), 0, 1, 3);
            chk($sformatf("drain%0d.rd_ptr", k), 32'(rd_ptr_o[0]), (k < 3) ? k + 1 : 3);
            chk($sformatf("drain%0d.rdempty", k), 32'(rdempty_o[0]), (k >= 2) ? 1 : 0);
            chk($sformatf("drain%0d.rdalmostempty", k), 32'(rdalmostempty_o[0]), (k >= 1) ? 1 : 0);
        end

        // Walk the read pointer to 14 and hold a full FIFO there, then wrap
        step("wrap_rst", 1, 0, 0);
        step("wrap_fill8", 0, 0, 8);
        chk("wrap_fill8.rdfull", 32'(rdfull_o[0]), 1);
        for (int k = 0; k < 8; k++) step("wrap_rd_a", 0, 1, 8);
        step("wrap_fill14", 0, 0, 14);
        for (int k = 0; k < 6; k++) step("wrap_rd_b", 0, 1, 14);
        step("full", 0, 0, 6);
        chk("full.rd_ptr", 32'(rd_ptr_o[0]), 14);
        chk("full.rdfull", 32'(rdfull_o[0]), 1);
        chk("full.rdusedw", 32'(rdusedw_o[0]), 0);
        step("full_rd1", 0, 1, 6);
        chk("full_rd1.rd_ptr", 32'(rd_ptr_o[0]), 15);
        chk("full_rd1.rdfull", 32'(rdfull_o[0]), 0);
        chk("full_rd1.rdusedw", 32'(rdusedw_o[0]), 7);
        step("full_rd2", 0, 1, 6);
        chk("full_rd2.rd_ptr", 32'(rd_ptr_o[0]), 0);
        chk("full_rd2.rdusedw", 32'(rdusedw_o[0]), 6);

        // Read and write pointer move on the same edge
        step("sim_rst", 1, 0, 0);
        step("sim_fill", 0, 0, 3);
        step("sim_rd", 0, 1, 3);
        step("sim_rd", 0, 1, 3);
        step("sim_both", 0, 1, 4);
        chk("sim_both.rd_ptr", 32'(rd_ptr_o[0]), 3);
        chk("sim_both.rdusedw", 32'(rdusedw_o[0]), 1);
        chk("sim_both.rdempty", 32'(rdempty_o[0]), 0);
        chk("sim_both.rdalmostempty", 32'(rdalmostempty_o[0]), 1);

        // Underflow into the error state on the unguarded instance
        step("err_rst", 1, 0, 0);
        step("err_fill", 0, 0, 4);
        for (int k = 0; k < 4; k++) step("err_rd", 0, 1, 4);
        step("err_under", 0, 1, 4);
        chk("err_under.on.rd_ptr", 32'(rd_ptr_o[0]), 4);
        chk("err_under.off.rd_ptr", 32'(rd_ptr_o[1]), 5);
        chk("err_under.off.rderr", 32'(rderr_o[1]), 1);
        chk("err_under.off.rdempty", 32'(rdempty_o[1]), 1);
        step("err_hold", 0, 1, 9);
        chk("err_hold.off.rd_ptr", 32'(rd_ptr_o[1]), 5);
        chk("err_hold.off.rderr", 32'(rderr_o[1]), 1);
        step("err_clr", 1, 0, 9);
        chk("err_clr.off.rderr", 32'(rderr_o[1]), 0);
        chk("err_clr.off.rd_ptr", 32'(rd_ptr_o[1]), 0);

        // Reset arriving together with a read
        step("mid_rst", 1, 0, 0);
        step("mid_fill", 0, 0, 8);
        for (int k = 0; k < 6; k++) step("mid_rd", 0, 1, 8);
        step("mid_sclr", 1, 1, 10);
        chk("mid_sclr.rd_ptr", 32'(rd_ptr_o[0]), 0);
        chk("mid_sclr.rdempty", 32'(rdempty_o[0]), 1);
        step("mid_after", 0, 0, 10);
        chk("mid_after.rdusedw", 32'(rdusedw_o[0]), 2);

        // Random traffic; write pointer advances without over-running the guarded instance
        step("rnd_rst", 1, 0, 0);
        for (int k = 0; k < 300; k++) begin
            int room, wp;
            bit sr;
            sr = ($urandom_range(0, 39) == 0);
            if (sr) begin
                wp = $urandom_range(0, 8);
            end else begin
                room = 8 - ((cur_wp - m_rd[0] + 16) % 16);
                if (room < 0) room = 0;
                wp = (cur_wp + $urandom_range(0, room)) % 16;
            end
            step($sformatf("rnd%0d", k), sr, 1'($urandom_range(0, 1)), wp);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
